perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
- Training sequencer that drives the perceptron's input side and observes its `out`.
- Holds a small buffer of labelled samples loaded by a host, replays them epoch by epoch and counts misclassifications per epoch.
- Stops when an epoch has zero errors (converged) or after MAX_EPOCHS epochs.
- Sits between the host/register interface and the perceptron instance.

Parameters:
- DEPTH, 8, number of sample slots in the buffer.
- AW, 3, address width; DEPTH == 2**AW.
- MAX_EPOCHS, 16, epoch limit; must be ≤ 255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  sample write strobe.
- wr_addr  in  AW  sample slot index.
- wr_data  in  16  packed sample: [3:0]=in1, [7:4]=in2, [14:8]=in3, [15]=desired.
- num_samples  in  AW+1  samples per epoch; sampled with start.
- start  in  1  begin a training run.
- perc_out  in  1  perceptron registered decision.
- perc_in1  out  4  to perceptron in1.
- perc_in2  out  4  to perceptron in2.
- perc_in3  out  7  to perceptron in3.
- perc_desired  out  1  to perceptron desired_out.
- busy  out  1  run in progress.
- done  out  1  run finished; level.
- converged  out  1  last run ended on a zero-error epoch.
- epoch_cnt  out  8  epochs completed in current/last run.
- err_cnt  out  AW+1  errors in most recently completed epoch.

Behaviour:
- Reset values (async, immediate):
  - State IDLE.
  - perc_in1/2/3 = 0; busy=0, done=0, converged=0, epoch_cnt=0, err_cnt=0.
  - Sample buffer is not reset.
- States: IDLE, PRESENT, EVAL, EPOCH_END, DONE.
- Writes:
  - In IDLE or DONE, wr_en writes wr_data to slot wr_addr at the edge.
  - Writes are ignored in other states.
  - Write and start in the same cycle: the write lands first and is visible to the run.
- Start (in IDLE or DONE):
  - Latch N = min(num_samples, DEPTH); clear epoch_cnt, running error count and converged; done=0.
  - N == 0 -> DONE next edge with converged=0, epoch_cnt=0.
  - Otherwise -> PRESENT with index=0.
  - start is ignored in PRESENT/EVAL/EPOCH_END.
- Weight-update masking (the perceptron compares its previous decision to the current desired_out):
  - perc_desired is combinational.
  - EVAL: perc_desired = stored desired bit of the current sample.
  - All other states: perc_desired = perc_out.
  - This guarantees no weight update outside EVAL.
- PRESENT (1 cycle):
  - Outputs perc_in* = sample[index] fields, registered and loaded on the edge entering PRESENT.
  - -> EVAL.
- EVAL (1 cycle):
  - Same inputs held; perc_out now reflects the decision on this sample.
  - At the exit edge, if perc_out != desired, increment the running error count (saturates at DEPTH).
  - Last index (index == N-1) -> EPOCH_END; otherwise index+1 -> PRESENT, loading the next sample.
- EPOCH_END (1 cycle):
  - perc_in* driven 0.
  - epoch_cnt += 1; err_cnt <= running count; running count cleared.
  - Running count == 0 -> DONE, converged=1.
  - Otherwise, epoch_cnt+1 == MAX_EPOCHS -> DONE, converged=0.
  - Otherwise -> PRESENT, index=0.
- DONE:
  - done=1 and busy=0; perc_in* = 0.
  - Held until start; epoch_cnt, err_cnt and converged hold their values.
- busy = 1 in PRESENT, EVAL, EPOCH_END.
- Timing: one epoch = 2N+1 cycles. done rises E*(2N+1) cycles after the start-sampling edge, where E is the number of epochs run.
- err_cnt is width AW+1 so that a value of DEPTH fits.
- Reset mid-run aborts immediately to the reset state. Perceptron weights are untouched by this block.

Test Plan:
- Load 1 sample {in1=2,in2=1,in3=5,d=0}; stub perc_out=0; N=1, start -> PRESENT, EVAL, EPOCH_END; done=1 exactly 3 cycles after start, converged=1, epoch_cnt=1, err_cnt=0.
- Stub perc_out=1 constant; sample d=0, N=1, MAX_EPOCHS=16 -> done after 48 cycles, converged=0, epoch_cnt=16, err_cnt=1.
- Masking: perc_out toggling randomly -> perc_desired == perc_out in every non-EVAL cycle, and == the stored desired bit in EVAL.
- With the real perceptron after reset, load 4 linearly separable samples (e.g. d=1 iff in3≥100) -> converged=1 within 16 epochs; the final epoch shows err_cnt=0.
- num_samples=0 -> done next edge, converged=0, epoch_cnt=0. num_samples=15 -> clamped to 8; epoch length 17 cycles.
- Assert reset mid-EVAL -> all outputs 0 in the same cycle. wr_en and start while busy are ignored; buffer contents unchanged, verified on the next run.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: host sample/control bus plus the perceptron drive/observe signals.
interface perceptron_trainer_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW:0]   num_samples;
    logic          start;
    logic          perc_out;
    logic [3:0]    perc_in1;
    logic [3:0]    perc_in2;
    logic [6:0]    perc_in3;
    logic          perc_desired;
    logic          busy;
    logic          done;
    logic          converged;
    logic [7:0]    epoch_cnt;
    logic [AW:0]   err_cnt;
    modport master (
        output wr_en, wr_addr, wr_data, num_samples, start, perc_out,
        input  perc_in1, perc_in2, perc_in3, perc_desired, busy, done, converged, epoch_cnt, err_cnt
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, num_samples, start, perc_out,
        output perc_in1, perc_in2, perc_in3, perc_desired, busy, done, converged, epoch_cnt, err_cnt
    );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: replays a host-loaded sample buffer into a perceptron epoch by epoch,
// counting misclassifications until an error-free epoch or the epoch limit.
module perceptron_trainer #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int MAX_EPOCHS = 16
) (
    input logic                 clk,
    input logic                 reset,
    perceptron_trainer_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, PRESENT = 3'd1, EVAL = 3'd2, EPOCH_END = 3'd3, DONE = 3'd4;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [7:0] MAX_W = MAX_EPOCHS[7:0];
    logic [2:0]    state;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   n, run_err, n_req;
    logic [AW-1:0] idx, load_idx;
    logic [15:0]   load_word;
    logic [7:0]    epoch_next;
    logic          desired, idle, last, miss, finish;
    always_comb begin
        idle = state == IDLE || state == DONE;
        load_idx = state == EVAL ? idx + 1'b1 : '0;
        // a write landing on the same edge as start must be seen by the first presented sample
        load_word = (idle && bus.wr_en && bus.wr_addr == load_idx) ? bus.wr_data : mem[load_idx];
        n_req = bus.num_samples > DEPTH_W ? DEPTH_W : bus.num_samples;
        last = {1'b0, idx} == n - 1'b1;
        miss = bus.perc_out != desired;
        epoch_next = bus.epoch_cnt + 8'd1;
        finish = run_err == '0 || epoch_next == MAX_W;
    end
    // outside EVAL the perceptron sees its own decision as the target, so it never updates
    assign bus.perc_desired = state == EVAL ? desired : bus.perc_out;
    assign bus.busy = state == PRESENT || state == EVAL || state == EPOCH_END;
    assign bus.done = state == DONE;
    always_ff @(posedge clk)
        if (idle && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            n <= '0;
            idx <= '0;
            run_err <= '0;
            desired <= 1'b0;
            bus.perc_in1 <= '0;
            bus.perc_in2 <= '0;
            bus.perc_in3 <= '0;
            bus.converged <= 1'b0;
            bus.epoch_cnt <= '0;
            bus.err_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    n <= n_req;
                    idx <= '0;
                    run_err <= '0;
                    bus.epoch_cnt <= '0;
                    bus.converged <= 1'b0;
                    state <= n_req == '0 ? DONE : PRESENT;
                    if (n_req != '0) {desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} <= load_word;
                end
                PRESENT: state <= EVAL;
                EVAL: begin
                    run_err <= (miss && run_err != DEPTH_W) ? run_err + 1'b1 : run_err;
                    idx <= idx + 1'b1;
                    state <= last ? EPOCH_END : PRESENT;
                    {desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} <= last ? '0 : load_word;
                end
                EPOCH_END: begin
                    bus.epoch_cnt <= epoch_next;
                    bus.err_cnt <= run_err;
                    bus.converged <= run_err == '0;
                    run_err <= '0;
                    idx <= '0;
                    state <= finish ? DONE : PRESENT;
                    if (!finish) {desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} <= load_word;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: randomized cycle-level check of the trainer against an epoch/sample
// schedule model, plus a behavioural perceptron for an end-to-end convergence run.
module tb_perceptron_trainer;
    localparam int MAXE = 16;
    logic clk = 0, reset = 1, stub = 0, use_model = 0, model_out = 0;
    int checks = 0, errors = 0, exp_err = 0;
    int w1, w2, w3, wb;
    logic [15:0] mem_m [8];

    perceptron_trainer_if #(.AW(3)) bus ();
    perceptron_trainer #(.DEPTH(8), .AW(3), .MAX_EPOCHS(MAXE)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.perc_out = use_model ? model_out : stub;

    // perceptron: registered decision, weights move toward desired when it disagrees with the last decision
    always @(posedge clk)
        if (use_model) begin
            if (model_out != bus.perc_desired) begin
                w1 += bus.perc_desired ? int'(bus.perc_in1) : -int'(bus.perc_in1);
                w2 += bus.perc_desired ? int'(bus.perc_in2) : -int'(bus.perc_in2);
                w3 += bus.perc_desired ? int'(bus.perc_in3) : -int'(bus.perc_in3);
                wb += bus.perc_desired ? 127 : -127;
            end
            model_out <= w1 * int'(bus.perc_in1) + w2 * int'(bus.perc_in2) + w3 * int'(bus.perc_in3) + wb > 0;
        end else begin
            w1 = 0; w2 = 0; w3 = 0; wb = 0;
            model_out <= 1'b0;
        end

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = v; mem_m[a] = v;
        @(negedge clk);
        bus.wr_en = 0;
    endtask

    // mode 0/1: perc_out held constant; mode 2: random, with misclassifications only in early epochs
    task automatic do_run(input int nreq, input int mode, input bit intrude, input bit ws);
        int n, e, errs, wrong_until;
        bit fin, conv, d;
        logic [15:0] s;
        n = nreq > 8 ? 8 : nreq;
        wrong_until = $urandom_range(0, 20);
        @(negedge clk);
        bus.num_samples = 4'(nreq);
        bus.start = 1;
        if (ws) begin
            s = 16'($urandom);
            bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = s; mem_m[0] = s;
        end
        @(negedge clk);
        bus.start = 0; bus.wr_en = 0;
        e = 0; fin = n == 0; conv = 0;
        while (!fin) begin
            errs = 0;
            for (int i = 0; i < n; i++) begin
                s = mem_m[i];
                stub = mode == 2 ? 1'($urandom) : 1'(mode);
                #1;
                checks++;
                if ({bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} !== {2'b10, stub, s[14:0]}) begin
                    errors++;
                    $display("FAIL present e%0d i%0d got %h exp %h", e, i,
                             {bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1}, {2'b10, stub, s[14:0]});
                end
                if (intrude && i == 0 && e == 0) begin
                    bus.wr_en = 1; bus.wr_addr = 3'($urandom); bus.wr_data = 16'($urandom);
                    bus.start = 1; bus.num_samples = 4'($urandom);
                end
                @(negedge clk);
                bus.wr_en = 0; bus.start = 0;
                d = s[15];
                stub = mode == 2 ? ((e < wrong_until && $urandom_range(0, 1) == 1) ? !d : d) : 1'(mode);
                #1;
                checks++;
                if ({bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} !== {2'b10, d, s[14:0]}) begin
                    errors++;
                    $display("FAIL eval e%0d i%0d got %h exp %h", e, i,
                             {bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1}, {2'b10, d, s[14:0]});
                end
                if (stub != d) errs++;
                @(negedge clk);
            end
            stub = mode == 2 ? 1'($urandom) : 1'(mode);
            #1;
            checks++;
            if ({bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1} !== {2'b10, stub, 15'd0}) begin
                errors++;
                $display("FAIL epoch_end e%0d got %h exp %h", e,
                         {bus.busy, bus.done, bus.perc_desired, bus.perc_in3, bus.perc_in2, bus.perc_in1}, {2'b10, stub, 15'd0});
            end
            @(negedge clk);
            e++;
            exp_err = errs;
            conv = errs == 0;
            fin = conv || e == MAXE;
            checks++;
            if ({bus.epoch_cnt, bus.err_cnt} !== {8'(e), 4'(errs)}) begin
                errors++;
                $display("FAIL counts epoch=%0d err=%0d exp epoch=%0d err=%0d", bus.epoch_cnt, bus.err_cnt, e, errs);
            end
        end
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.converged, bus.epoch_cnt, bus.err_cnt, bus.perc_in3, bus.perc_in2, bus.perc_in1}
            !== {2'b01, conv, 8'(e), 4'(exp_err), 15'd0}) begin
            errors++;
            $display("FAIL done n=%0d got busy=%b done=%b conv=%b epoch=%0d err=%0d exp conv=%b epoch=%0d err=%0d",
                     nreq, bus.busy, bus.done, bus.converged, bus.epoch_cnt, bus.err_cnt, conv, e, exp_err);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.converged, bus.epoch_cnt, bus.err_cnt, bus.perc_in3, bus.perc_in2, bus.perc_in1, bus.perc_desired}
            !== {3'b000, 8'd0, 4'd0, 15'd0, stub}) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b conv=%b epoch=%0d err=%0d ins=%h", bus.busy, bus.done,
                     bus.converged, bus.epoch_cnt, bus.err_cnt, {bus.perc_in3, bus.perc_in2, bus.perc_in1});
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_single;
        wr(0, {1'b0, 7'd5, 4'd1, 4'd2});
        do_run(1, 0, 0, 0);
    endtask

    task automatic test_max_epochs;
        do_run(1, 1, 0, 0);
    endtask

    task automatic test_reset_mid_eval;
        @(negedge clk);
        bus.num_samples = 4'd3; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.converged, bus.epoch_cnt, bus.err_cnt, bus.perc_in3, bus.perc_in2, bus.perc_in1}
            !== {3'b000, 8'd0, 4'd0, 15'd0}) begin
            errors++;
            $display("FAIL reset_mid_eval got busy=%b done=%b epoch=%0d err=%0d ins=%h", bus.busy, bus.done,
                     bus.epoch_cnt, bus.err_cnt, {bus.perc_in3, bus.perc_in2, bus.perc_in1});
        end
        @(negedge clk);
        reset = 0;
        exp_err = 0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) wr(3'(i), 16'($urandom));
        repeat (6) do_run($urandom_range(1, 8), 2, 0, 0);
    endtask

    task automatic test_bounds;
        do_run(0, 2, 0, 0);
        do_run(15, 2, 0, 0);
    endtask

    task automatic test_back_to_back;
        do_run(8, 2, 1, 0);
        do_run(8, 2, 0, 0);
    endtask

    task automatic test_write_start;
        do_run(1, 2, 0, 1);
        do_run(2, 2, 0, 1);
    endtask

    task automatic test_perceptron;
        int cyc;
        wr(0, {1'b1, 7'd120, 8'd0});
        wr(1, {1'b0, 7'd10, 8'd0});
        wr(2, {1'b1, 7'd110, 8'd0});
        wr(3, {1'b0, 7'd20, 8'd0});
        @(negedge clk);
        use_model = 1;
        bus.num_samples = 4'd4; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        cyc = 0;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL perceptron_timeout done=%b after %0d cycles", bus.done, cyc);
        end
        checks++;
        if ({bus.converged, bus.err_cnt} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL perceptron_conv got conv=%b err=%0d exp conv=1 err=0", bus.converged, bus.err_cnt);
        end
        checks++;
        if (bus.epoch_cnt == 8'd0 || bus.epoch_cnt > 8'(MAXE) || cyc != int'(bus.epoch_cnt) * 9) begin
            errors++;
            $display("FAIL perceptron_epochs epoch=%0d cycles=%0d exp cycles=epoch*9", bus.epoch_cnt, cyc);
        end
        use_model = 0;
        exp_err = 0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.num_samples = 0; bus.start = 0;
        test_reset;
        test_single;
        test_max_epochs;
        test_reset_mid_eval;
        test_random;
        test_bounds;
        test_back_to_back;
        test_write_start;
        test_perceptron;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
